// File: rtl/chip8_mem_responder.sv
// Responder for chip-8 core/video memory requests: 4 KiB program RAM plus double-buffered VRAM.
// Build with CHIP8_MEM_PROTOCOL_CHECK_EN to get the sticky protocol-error flag on err_out.
module chip8_mem_responder #(
    parameter int RAM_DEPTH    = 4096,
    parameter int VRAM_BYTES   = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    input  logic        req_we_in,
    input  logic        req_type_in,
    input  logic [15:0] req_addr_in,
    input  logic [7:0]  req_data_in,
    output logic        req_ready_out,
    output logic        rsp_valid_out,
    output logic [7:0]  rsp_data_out,
    input  logic        swap_in,
    output logic        front_sel_out,
    output logic        copy_busy_out,
    input  logic [7:0]  disp_addr_in,
    output logic [7:0]  disp_data_out,
    output logic        err_out
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int VW = $clog2(VRAM_BYTES);
    localparam int CW = 3;
    localparam logic [CW-1:0] WAIT_INIT = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [VW:0]   COPY_LAST = (VW+1)'(VRAM_BYTES);

    typedef enum logic [1:0] {IDLE, READ_WAIT, COPY} state_t;

    state_t        state_q;
    logic          ready_q, rsp_valid_q, front_q, busy_q, pend_q;
    logic [7:0]    rsp_data_q, disp_q, copy_data_q;
    logic [CW-1:0] cnt_q;
    logic [VW:0]   idx_q;
    logic          rd_type_q, rd_bank_q;
    logic [AW-1:0] rd_addr_q;

    logic [7:0] ram_q  [RAM_DEPTH];
    logic [7:0] vram_q [2*VRAM_BYTES];

    logic          accept, ram_we, vram_we, copy_we;
    logic [AW-1:0] ram_addr;
    logic [VW-1:0] vram_addr, copy_wr_addr;

    assign ram_addr     = req_addr_in[AW-1:0];
    assign vram_addr    = req_addr_in[VW-1:0];
    assign accept       = req_valid_in & ready_q;
    assign ram_we       = accept & req_we_in & ~req_type_in;
    assign vram_we      = accept & req_we_in & req_type_in;
    assign copy_we      = (state_q == COPY) && (idx_q != '0);
    assign copy_wr_addr = VW'(idx_q - 1'b1);

    // VRAM is one array indexed {bank, byte}; the drawing side always targets the back bank.
    function automatic logic [7:0] rd_byte(input logic t, input logic bank, input logic [AW-1:0] a);
        return t ? vram_q[{bank, a[VW-1:0]}] : ram_q[a];
    endfunction

    always_ff @(posedge clk_in) begin
        if (ram_we)  ram_q[ram_addr] <= req_data_in;
        if (vram_we) vram_q[{~front_q, vram_addr}] <= req_data_in;
        if (copy_we) vram_q[{~front_q, copy_wr_addr}] <= copy_data_q;
        // Copy pipeline: front[i] fetched on step i, written to back on step i+1.
        copy_data_q <= vram_q[{front_q, idx_q[VW-1:0]}];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            front_q     <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            disp_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            rd_type_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            disp_q      <= vram_q[{front_q, disp_addr_in}];
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (swap_in) pend_q <= 1'b1;
                        if (!req_we_in && READ_LATENCY == 1) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rd_byte(req_type_in, ~front_q, ram_addr);
                            ready_q     <= 1'b1;
                        end else if (!req_we_in) begin
                            state_q   <= READ_WAIT;
                            ready_q   <= 1'b0;
                            cnt_q     <= WAIT_INIT;
                            rd_type_q <= req_type_in;
                            rd_bank_q <= ~front_q;
                            rd_addr_q <= ram_addr;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end else if (swap_in || pend_q) begin
                        state_q <= COPY;
                        front_q <= ~front_q;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (swap_in) pend_q <= 1'b1;
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rd_byte(rd_type_q, rd_bank_q, rd_addr_q);
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                COPY: begin
                    // A swap queued during the copy chains straight into the next one.
                    if (idx_q == COPY_LAST) begin
                        if (pend_q || swap_in) begin
                            front_q <= ~front_q;
                            pend_q  <= 1'b0;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (swap_in) pend_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CHIP8_MEM_PROTOCOL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            err_q <= 1'b0;
        end else if (req_valid_in && (!ready_q
                     || (!req_type_in && (|req_addr_in[15:12]))
                     || ( req_type_in && (|req_addr_in[15:8])))) begin
            err_q <= 1'b1;
        end
    end

    assign err_out = err_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_in[15:12];
    assign err_out        = 1'b0;
`endif

    assign req_ready_out = ready_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_data_out  = rsp_data_q;
    assign front_sel_out = front_q;
    assign copy_busy_out = busy_q;
    assign disp_data_out = disp_q;

endmodule
